// File: rtl/instr_mem_resp_if.sv
// ---------------------------------------------------------------------------
// instr_mem_resp_if
// Bus between the fetch/load side (master) and the instruction-memory
// responder (slave).
//   load_start, load_wr, load_data, load_last : program-load controls
//   fetch_en, instr_addr, flush               : fetch request from the PC
//   instr_out, instr_valid                    : fetched instruction word
//   load_cnt, state_out, halt_out             : status
//   addr_err                                  : sticky out-of-range fetch flag,
//                                               present only when
//                                               ADDR_RANGE_CHECK_EN is defined
// ---------------------------------------------------------------------------
interface instr_mem_resp_if #(
  parameter int IW = 9,
  parameter int AW = 8
);
  logic          load_start;
  logic          load_wr;
  logic [IW-1:0] load_data;
  logic          load_last;
  logic          fetch_en;
  logic [15:0]   instr_addr;
  logic          flush;
  logic [IW-1:0] instr_out;
  logic          instr_valid;
  logic [AW:0]   load_cnt;
  logic [1:0]    state_out;
  logic          halt_out;
`ifdef ADDR_RANGE_CHECK_EN
  logic          addr_err;
`endif

  modport master (
    output load_start, load_wr, load_data, load_last,
    output fetch_en, instr_addr, flush,
`ifdef ADDR_RANGE_CHECK_EN
    input  addr_err,
`endif
    input  instr_out, instr_valid, load_cnt, state_out, halt_out
  );

  modport slave (
    input  load_start, load_wr, load_data, load_last,
    input  fetch_en, instr_addr, flush,
`ifdef ADDR_RANGE_CHECK_EN
    output addr_err,
`endif
    output instr_out, instr_valid, load_cnt, state_out, halt_out
  );
endinterface

// File: rtl/instr_mem_resp.sv
// ---------------------------------------------------------------------------
// instr_mem_resp
// Instruction-memory responder at the far end of the fetch path.
//   - IDLE -> LOAD on load_start; LOAD writes words sequentially from word 0
//     and moves to RUN after the last word (load_last or the top word).
//   - RUN: an address sampled with fetch_en at edge N is read at edge N+1,
//     so instr_out/instr_valid reflect it after edge N+1. flush at the same
//     edge as fetch_en discards the request.
//   - Fetching HALT_OP sets sticky halt_out and freezes everything in HALT.
// Ports:
//   CLK        : clock, rising edge
//   reset_ctrl : synchronous active-high reset (memory contents are kept)
//   bus        : instr_mem_resp_if.slave (load, fetch and status signals)
// Configuration:
//   ADDR_RANGE_CHECK_EN : when defined, a fetch with instr_addr[15:AW] != 0
//   returns NOP_OP with instr_valid 1 and sets sticky bus.addr_err; when not
//   defined the upper address bits are ignored and addresses alias.
// ---------------------------------------------------------------------------
module instr_mem_resp #(
  parameter int            IW      = 9,
  parameter int            AW      = 8,
  parameter logic [IW-1:0] HALT_OP = 9'h1FF,
  parameter logic [IW-1:0] NOP_OP  = 9'h000
) (
  input logic              CLK,
  input logic              reset_ctrl,
  instr_mem_resp_if.slave  bus
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          req_valid_q, req_valid_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic [IW-1:0] out_q, out_d;
  logic          valid_q, valid_d;
  logic          halt_q, halt_d;
  logic          mem_we;
  logic [IW-1:0] rd_data;
  logic          req_err_q, req_err_d;
  logic          addr_err_q, addr_err_d;
  logic          range_bad;

  logic [IW-1:0] mem [DEPTH];

  assign rd_data = mem[req_addr_q];

`ifdef ADDR_RANGE_CHECK_EN
  assign range_bad    = |bus.instr_addr[15:AW];
  assign bus.addr_err = addr_err_q;
`else
  // Upper address bits only alias into the memory in this build.
  logic unused_upper_addr;
  assign unused_upper_addr = ^bus.instr_addr[15:AW];
  assign range_bad         = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_err_d   = req_err_q;
    out_d       = out_q;
    valid_d     = valid_q;
    halt_d      = halt_q;
    addr_err_d  = addr_err_q;
    mem_we      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
        end
      end

      ST_LOAD: begin
        if (bus.load_wr) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          if (cnt_q != (AW+1)'(DEPTH)) cnt_d = cnt_q + 1'b1;
          if (bus.load_last || ptr_q == AW'(DEPTH - 1)) state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Request stage: flush squashes the address sampled at this edge.
        req_valid_d = bus.fetch_en && !bus.flush;
        req_addr_d  = bus.instr_addr[AW-1:0];
        req_err_d   = range_bad;

        // Response stage: read the request captured at the previous edge.
        valid_d = req_valid_q;
        out_d   = NOP_OP;
        if (req_valid_q) begin
          if (req_err_q) begin
            addr_err_d = 1'b1;
          end else begin
            out_d = rd_data;
            if (rd_data == HALT_OP) begin
              halt_d  = 1'b1;
              state_d = ST_HALT;
            end
          end
        end
      end

      ST_HALT: begin
        // Everything holds until reset.
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (reset_ctrl) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_err_q   <= 1'b0;
      out_q       <= NOP_OP;
      valid_q     <= 1'b0;
      halt_q      <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_err_q   <= req_err_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      halt_q      <= halt_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // NOTE: the memory array has no reset; its contents must survive reset so
  // a program can be re-run, and leaving it out keeps it mappable to RAM.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[ptr_q] <= bus.load_data;
  end

  assign bus.instr_out   = out_q;
  assign bus.instr_valid = valid_q;
  assign bus.load_cnt    = cnt_q;
  assign bus.state_out   = state_q;
  assign bus.halt_out    = halt_q;

endmodule

// File: tb/tb_instr_mem_resp.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_resp
// Directed bench for instr_mem_resp: reset, program load, fetch latency,
// flush, back-to-back fetches, reset mid-load, full-depth load, address
// range handling (both builds of ADDR_RANGE_CHECK_EN) and halt.
// ---------------------------------------------------------------------------
module tb_instr_mem_resp;
  localparam int IW = 9;
  localparam int AW = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  instr_mem_resp_if #(.IW(IW), .AW(AW)) bus ();

  instr_mem_resp #(.IW(IW), .AW(AW)) dut (
    .CLK       (clk),
    .reset_ctrl(rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_start = 1'b0;
    bus.load_wr    = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    bus.fetch_en   = 1'b0;
    bus.instr_addr = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic load_word(input logic [IW-1:0] data, input logic last);
    bus.load_wr   = 1'b1;
    bus.load_data = data;
    bus.load_last = last;
    tick();
    bus.load_wr   = 1'b0;
    bus.load_last = 1'b0;
  endtask

  // Presents one fetch, then waits for its response edge.
  task automatic do_fetch(input logic [15:0] addr, input logic fl);
    bus.fetch_en   = 1'b1;
    bus.instr_addr = addr;
    bus.flush      = fl;
    tick();
    bus.fetch_en = 1'b0;
    bus.flush    = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.state_out !== 2'b00) begin bad++; $display("FAIL reset_state: got %b want 00", bus.state_out); end
    total++; if (bus.load_cnt !== 9'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", bus.load_cnt); end
    total++; if (bus.instr_out !== 9'h000) begin bad++; $display("FAIL reset_instr: got %h want 000", bus.instr_out); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
    total++; if (bus.halt_out !== 1'b0) begin bad++; $display("FAIL reset_halt: got %b want 0", bus.halt_out); end
    // fetch_en is ignored in IDLE
    do_fetch(16'h0001, 1'b0);
    total++; if (bus.instr_valid !== 1'b0 || bus.state_out !== 2'b00) begin
      bad++; $display("FAIL idle_fetch: valid=%b state=%b want 0/00", bus.instr_valid, bus.state_out); end
  endtask

  task automatic test_load();
    start_load();
    total++; if (bus.state_out !== 2'b01) begin bad++; $display("FAIL load_enter: got %b want 01", bus.state_out); end
    load_word(9'h011, 1'b0);
    total++; if (bus.load_cnt !== 9'd1) begin bad++; $display("FAIL load_cnt1: got %0d want 1", bus.load_cnt); end
    // load_wr low holds; load_start is ignored in LOAD
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    total++; if (bus.load_cnt !== 9'd1 || bus.state_out !== 2'b01) begin
      bad++; $display("FAIL load_hold: cnt=%0d state=%b want 1/01", bus.load_cnt, bus.state_out); end
    load_word(9'h022, 1'b0);
    load_word(9'h033, 1'b1);
    total++; if (bus.load_cnt !== 9'd3) begin bad++; $display("FAIL load_cnt3: got %0d want 3", bus.load_cnt); end
    total++; if (bus.state_out !== 2'b10) begin bad++; $display("FAIL load_to_run: got %b want 10", bus.state_out); end
  endtask

  task automatic test_fetch();
    do_fetch(16'h0001, 1'b0);
    total++; if (bus.instr_out !== 9'h022 || bus.instr_valid !== 1'b1) begin
      bad++; $display("FAIL fetch_addr1: out=%h valid=%b want 022/1", bus.instr_out, bus.instr_valid); end
    tick();
    total++; if (bus.instr_out !== 9'h000 || bus.instr_valid !== 1'b0) begin
      bad++; $display("FAIL fetch_idle: out=%h valid=%b want 000/0", bus.instr_out, bus.instr_valid); end
  endtask

  task automatic test_flush();
    do_fetch(16'h0000, 1'b1);
    total++; if (bus.instr_out !== 9'h000 || bus.instr_valid !== 1'b0) begin
      bad++; $display("FAIL flush_squash: out=%h valid=%b want 000/0", bus.instr_out, bus.instr_valid); end
    do_fetch(16'h0002, 1'b0);
    total++; if (bus.instr_out !== 9'h033 || bus.instr_valid !== 1'b1) begin
      bad++; $display("FAIL flush_refetch: out=%h valid=%b want 033/1", bus.instr_out, bus.instr_valid); end
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] exp_words [3];
    exp_words[0] = 9'h011;
    exp_words[1] = 9'h022;
    exp_words[2] = 9'h033;
    bus.fetch_en   = 1'b1;
    bus.instr_addr = 16'h0000;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) bus.instr_addr = 16'(i + 1);
      else       bus.fetch_en   = 1'b0;
      tick();
      total++; if (bus.instr_out !== exp_words[i] || bus.instr_valid !== 1'b1) begin
        bad++; $display("FAIL b2b_%0d: out=%h valid=%b want %h/1", i, bus.instr_out, bus.instr_valid, exp_words[i]); end
    end
    tick();
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: valid=%b want 0", bus.instr_valid); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    start_load();
    load_word(9'h0AA, 1'b0);
    load_word(9'h0BB, 1'b0);
    do_reset();
    total++; if (bus.state_out !== 2'b00 || bus.load_cnt !== 9'd0) begin
      bad++; $display("FAIL midload_reset: state=%b cnt=%0d want 00/0", bus.state_out, bus.load_cnt); end
    start_load();
    load_word(9'h0CC, 1'b1);
    total++; if (bus.state_out !== 2'b10 || bus.load_cnt !== 9'd1) begin
      bad++; $display("FAIL reload_run: state=%b cnt=%0d want 10/1", bus.state_out, bus.load_cnt); end
    do_fetch(16'h0000, 1'b0);
    total++; if (bus.instr_out !== 9'h0CC) begin bad++; $display("FAIL reload_word0: got %h want 0CC", bus.instr_out); end
    // memory survives reset: word 1 still holds the earlier write
    do_fetch(16'h0001, 1'b0);
    total++; if (bus.instr_out !== 9'h0BB) begin bad++; $display("FAIL mem_kept: got %h want 0BB", bus.instr_out); end
  endtask

  task automatic test_full_load();
    logic [IW-1:0] d;
    do_reset();
    start_load();
    for (int i = 0; i < 256; i++) begin
      d = 9'(i) ^ 9'h0A5;
      load_word(d, 1'b0);
      if (i == 254) begin
        total++; if (bus.state_out !== 2'b01) begin bad++; $display("FAIL full_255: state=%b want 01", bus.state_out); end
      end
    end
    total++; if (bus.state_out !== 2'b10 || bus.load_cnt !== 9'd256) begin
      bad++; $display("FAIL full_last: state=%b cnt=%0d want 10/256", bus.state_out, bus.load_cnt); end
    // a stray load_wr in RUN is ignored
    load_word(9'h123, 1'b0);
    total++; if (bus.load_cnt !== 9'd256) begin bad++; $display("FAIL full_sat: cnt=%0d want 256", bus.load_cnt); end
    do_fetch(16'h00FF, 1'b0);
    total++; if (bus.instr_out !== 9'h05A) begin bad++; $display("FAIL full_top: got %h want 05A", bus.instr_out); end
    do_fetch(16'h0000, 1'b0);
    total++; if (bus.instr_out !== 9'h0A5) begin bad++; $display("FAIL full_bottom: got %h want 0A5", bus.instr_out); end
  endtask

  task automatic test_addr_range();
    do_reset();
    start_load();
    load_word(9'h011, 1'b0);
    load_word(9'h022, 1'b0);
    load_word(9'h033, 1'b0);
    load_word(9'h044, 1'b0);
    load_word(9'h1FF, 1'b0);
    load_word(9'h155, 1'b1);
    total++; if (bus.load_cnt !== 9'd6) begin bad++; $display("FAIL range_cnt: got %0d want 6", bus.load_cnt); end
`ifdef ADDR_RANGE_CHECK_EN
    total++; if (bus.addr_err !== 1'b0) begin bad++; $display("FAIL range_err0: got %b want 0", bus.addr_err); end
    do_fetch(16'h0105, 1'b0);
    total++; if (bus.instr_out !== 9'h000 || bus.instr_valid !== 1'b1 || bus.addr_err !== 1'b1) begin
      bad++; $display("FAIL range_bad: out=%h valid=%b err=%b want 000/1/1", bus.instr_out, bus.instr_valid, bus.addr_err); end
    do_fetch(16'h0005, 1'b0);
    total++; if (bus.instr_out !== 9'h155 || bus.addr_err !== 1'b1) begin
      bad++; $display("FAIL range_sticky: out=%h err=%b want 155/1", bus.instr_out, bus.addr_err); end
`else
    do_fetch(16'h0105, 1'b0);
    total++; if (bus.instr_out !== 9'h155 || bus.instr_valid !== 1'b1) begin
      bad++; $display("FAIL range_alias: out=%h valid=%b want 155/1", bus.instr_out, bus.instr_valid); end
`endif
  endtask

  task automatic test_halt();
    do_fetch(16'h0004, 1'b0);
    total++; if (bus.instr_out !== 9'h1FF || bus.instr_valid !== 1'b1 || bus.halt_out !== 1'b1 || bus.state_out !== 2'b11) begin
      bad++; $display("FAIL halt_enter: out=%h valid=%b halt=%b state=%b want 1FF/1/1/11",
                      bus.instr_out, bus.instr_valid, bus.halt_out, bus.state_out); end
    bus.fetch_en   = 1'b1;
    bus.instr_addr = 16'h0001;
    bus.load_start = 1'b1;
    tick();
    tick();
    tick();
    idle_inputs();
    total++; if (bus.instr_out !== 9'h1FF || bus.instr_valid !== 1'b1 || bus.halt_out !== 1'b1 || bus.state_out !== 2'b11) begin
      bad++; $display("FAIL halt_hold: out=%h valid=%b halt=%b state=%b want 1FF/1/1/11",
                      bus.instr_out, bus.instr_valid, bus.halt_out, bus.state_out); end
    do_reset();
    total++; if (bus.halt_out !== 1'b0 || bus.state_out !== 2'b00 || bus.instr_valid !== 1'b0) begin
      bad++; $display("FAIL halt_reset: halt=%b state=%b valid=%b want 0/00/0", bus.halt_out, bus.state_out, bus.instr_valid); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_load();
    test_fetch();
    test_flush();
    test_back_to_back();
    test_reset_mid_load();
    test_full_load();
    test_addr_range();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
